// File: rtl/comparador_serie_msb_pkg.sv
// Shared definitions for the bit-serial MSB-first magnitude comparator.
// Holds the controller state encoding used by the top level.
package comparador_serie_msb_pkg;

  // Controller states; the unused code 2'd3 is treated as IDLE by the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int counterWidth(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/comparador_serie_msb_celda.sv
// Single comparison cell for the MSB-first serial comparator.
// While neither flag is set, the current bit pair decides the flags.
// Once a flag is set it is held and later bit pairs have no effect.
// Built structurally from gate primitives.
module celda_serie_msb (
  input  logic gt_in,
  input  logic lt_in,
  input  logic A,
  input  logic B,
  output logic gt_out,
  output logic lt_out
);

  logic w_nA;
  logic w_nB;
  logic w_nGt;
  logic w_nLt;
  logic w_open;
  logic w_setGt;
  logic w_setLt;

  not u_invA  (w_nA,  A);
  not u_invB  (w_nB,  B);
  not u_invGt (w_nGt, gt_in);
  not u_invLt (w_nLt, lt_in);

  // The word is still undecided only while both flags are clear.
  and u_open  (w_open,  w_nGt, w_nLt);

  // First differing bit: A=1,B=0 means greater; A=0,B=1 means less.
  and u_setGt (w_setGt, w_open, A,    w_nB);
  and u_setLt (w_setLt, w_open, w_nA, B);

  or  u_gtOut (gt_out, gt_in, w_setGt);
  or  u_ltOut (lt_out, lt_in, w_setLt);

endmodule

// File: rtl/comparador_serie_msb.sv
// Bit-serial magnitude comparator, MSB first.
// Consumes one (A,B) pair per accepted transfer for N transfers, then
// pulses done for one cycle. The gt/lt/eq/Z results are held until the
// next start.
module comparador_serie_msb
  import comparador_serie_msb_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = counterWidth(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic A,
  input  logic B,
  output logic busy,
  output logic done,
  output logic gt,
  output logic lt,
  output logic eq,
  output logic Z
);

  state_t          r_state;
  state_t          w_stateNext;
  logic [CW-1:0]   r_count;
  logic            r_gt;
  logic            r_lt;
  logic            w_inRun;
  logic            w_inIdle;
  logic            w_xfer;
  logic            w_lastXfer;
  logic            w_startClear;
  logic            w_gtNext;
  logic            w_ltNext;

  assign w_inRun      = (r_state == ST_RUN);
  assign w_inIdle     = (r_state == ST_IDLE) || (r_state == ST_DONE ? 1'b0 : (r_state != ST_RUN));
  assign w_xfer       = bit_valid & w_inRun;
  assign w_lastXfer   = w_xfer & (r_count == CW'(N - 1));
  assign w_startClear = w_inIdle & start;

  celda_serie_msb u_celda (
    .gt_in  (r_gt),
    .lt_in  (r_lt),
    .A      (A),
    .B      (B),
    .gt_out (w_gtNext),
    .lt_out (w_ltNext)
  );

  // State register; reset forces IDLE regardless of any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake/status outputs; the unused encoding behaves as IDLE.
  always_comb begin
    w_stateNext = ST_IDLE;
    bit_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_RUN: begin
        bit_ready   = 1'b1;
        busy        = 1'b1;
        w_stateNext = w_lastXfer ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = start ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  // Transfer counter and result flags: cleared by start, updated per transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else if (w_startClear) begin
      r_count <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else if (w_xfer) begin
      r_count <= r_count + CW'(1);
      r_gt    <= w_gtNext;
      r_lt    <= w_ltNext;
    end
  end

  assign gt = r_gt;
  assign lt = r_lt;
  assign eq = ~r_gt & ~r_lt;
  assign Z  = ~r_gt;

endmodule

// File: tb/tb_comparador_serie_msb.sv
// Directed self-checking bench for the MSB-first serial comparator.
// A 4-bit instance covers the main scenarios; a 1-bit instance covers
// the single-transfer word.
module tb_comparador_serie_msb;

  logic clk;
  logic rst_n;

  logic start;
  logic bit_valid;
  logic bit_ready;
  logic A;
  logic B;
  logic busy;
  logic done;
  logic gt;
  logic lt;
  logic eq;
  logic Z;

  logic start1;
  logic bitValid1;
  logic bitReady1;
  logic A1;
  logic B1;
  logic busy1;
  logic done1;
  logic gt1;
  logic lt1;
  logic eq1;
  logic Z1;

  int testsRun;
  int testsFailed;

  comparador_serie_msb #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .Z         (Z)
  );

  comparador_serie_msb #(.N(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .bit_valid (bitValid1),
    .bit_ready (bitReady1),
    .A         (A1),
    .B         (B1),
    .busy      (busy1),
    .done      (done1),
    .gt        (gt1),
    .lt        (lt1),
    .eq        (eq1),
    .Z         (Z1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runs one 4-bit word on the N=4 instance. Inputs change on negedges.
  // Returns the number of rising edges from the start edge until done is seen.
  task automatic runWord(input logic [3:0] a, input logic [3:0] b,
                         input int stallAfter, input int stallLen,
                         input bit disturb, output int edges);
    int   idx;
    int   stalled;
    logic xfer;
    idx     = 0;
    stalled = 0;
    edges   = 0;
    start     = 1'b1;
    bit_valid = 1'b0;
    A         = 1'b0;
    B         = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = disturb;
    while (done !== 1'b1 && edges < 40) begin
      if (idx < 4 && !(idx == stallAfter && stalled < stallLen)) begin
        bit_valid = 1'b1;
        A = a[3-idx];
        B = b[3-idx];
      end else begin
        bit_valid = 1'b0;
        A = 1'b1;
        B = 1'b0;
      end
      xfer = bit_valid & bit_ready;
      @(posedge clk);
      edges++;
      if (xfer) idx++;
      else if (idx == stallAfter) stalled++;
      @(negedge clk);
    end
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    // Values straight out of the initial reset
    testsRun++;
    if ({busy, done, bit_ready, gt, lt, eq, Z} !== 7'b0000011) begin
      testsFailed++;
      $display("[TB] FAIL reset_initial: got busy,done,rdy,gt,lt,eq,Z=%b expected 0000011",
               {busy, done, bit_ready, gt, lt, eq, Z});
    end
    // Start a run, decide gt on the first bit, then reset mid-run
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b1; A = 1'b1; B = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b1; A = 1'b0; B = 1'b0;
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b1 || gt !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_prerun: got busy=%b gt=%b expected busy=1 gt=1", busy, gt);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bit_valid = 1'b0;
    testsRun++;
    if ({busy, done, bit_ready, gt, lt, eq, Z} !== 7'b0000011) begin
      testsFailed++;
      $display("[TB] FAIL reset_midrun: got busy,done,rdy,gt,lt,eq,Z=%b expected 0000011",
               {busy, done, bit_ready, gt, lt, eq, Z});
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle_hold: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_greater();
    int edges;
    runWord(4'b1010, 4'b1001, 99, 0, 1'b0, edges);
    testsRun++;
    if (edges !== 5) begin
      testsFailed++;
      $display("[TB] FAIL gt_latency: got %0d edges to done expected 5", edges);
    end
    testsRun++;
    if ({gt, lt, eq, Z} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL gt_result: got gt,lt,eq,Z=%b expected 1000", {gt, lt, eq, Z});
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (done !== 1'b0 || busy !== 1'b0 || {gt, lt, eq, Z} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL gt_after_done: got done=%b busy=%b gt,lt,eq,Z=%b expected 0 0 1000",
               done, busy, {gt, lt, eq, Z});
    end
  endtask

  task automatic test_less_sticky();
    int edges;
    runWord(4'b0111, 4'b1000, 99, 0, 1'b0, edges);
    testsRun++;
    if (edges !== 5) begin
      testsFailed++;
      $display("[TB] FAIL lt_latency: got %0d edges to done expected 5", edges);
    end
    testsRun++;
    if ({gt, lt, eq, Z} !== 4'b0101) begin
      testsFailed++;
      $display("[TB] FAIL lt_sticky: got gt,lt,eq,Z=%b expected 0101", {gt, lt, eq, Z});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_stall_equal();
    int edges;
    runWord(4'b1100, 4'b1100, 2, 3, 1'b0, edges);
    testsRun++;
    if (edges !== 8) begin
      testsFailed++;
      $display("[TB] FAIL stall_latency: got %0d edges to done expected 8", edges);
    end
    testsRun++;
    if ({gt, lt, eq, Z} !== 4'b0011) begin
      testsFailed++;
      $display("[TB] FAIL stall_equal: got gt,lt,eq,Z=%b expected 0011", {gt, lt, eq, Z});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int edges;
    // Valid pair offered while idle must be ignored
    bit_valid = 1'b1; A = 1'b1; B = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b0;
    testsRun++;
    if (busy !== 1'b0 || {gt, lt} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL idle_valid: got busy=%b gt,lt=%b expected 0 00", busy, {gt, lt});
    end
    // start held high during RUN must not restart the word
    runWord(4'b0110, 4'b0110, 99, 0, 1'b1, edges);
    testsRun++;
    if (edges !== 5) begin
      testsFailed++;
      $display("[TB] FAIL disturb_latency: got %0d edges to done expected 5", edges);
    end
    // Valid pair offered during DONE and the following IDLE must be ignored
    bit_valid = 1'b1; A = 1'b1; B = 1'b0;
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL disturb_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
    @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b0;
    testsRun++;
    if ({gt, lt, eq, Z} !== 4'b0011 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL disturb_result: got gt,lt,eq,Z=%b busy=%b expected 0011 0",
               {gt, lt, eq, Z}, busy);
    end
  endtask

  task automatic test_single_bit();
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    testsRun++;
    if (busy1 !== 1'b1 || bitReady1 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL n1_run: got busy=%b ready=%b expected 1 1", busy1, bitReady1);
    end
    bitValid1 = 1'b1; A1 = 1'b1; B1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bitValid1 = 1'b0;
    testsRun++;
    if (done1 !== 1'b1 || {gt1, lt1, eq1, Z1} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL n1_done: got done=%b gt,lt,eq,Z=%b expected 1 1000",
               done1, {gt1, lt1, eq1, Z1});
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (done1 !== 1'b0 || gt1 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL n1_hold: got done=%b gt=%b expected 0 1", done1, gt1);
    end
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    testsRun++;
    if ({gt1, lt1} !== 2'b00 || busy1 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL n1_restart_clear: got gt,lt=%b busy=%b expected 00 1",
               {gt1, lt1}, busy1);
    end
  endtask

  // Test sequence: reset, then each scenario in turn, then the summary.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    A         = 1'b0;
    B         = 1'b0;
    start1    = 1'b0;
    bitValid1 = 1'b0;
    A1        = 1'b0;
    B1        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_greater();
    test_less_sticky();
    test_stall_equal();
    test_back_to_back();
    test_single_bit();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
